// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage byte-serial memory controller.
// Holds the access-size encodings, the controller state encoding and the size decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MemwNo = 2'd0,
    MemwSb = 2'd1,
    MemwSh = 2'd2,
    MemwSw = 2'd3
  } memw_e;

  localparam int unsigned MemCtrlStateLen = 2;

  typedef enum logic [MemCtrlStateLen-1:0] {
    McIdle  = 2'd0,
    McRead  = 2'd1,
    McWrite = 2'd2,
    McDone  = 2'd3
  } mc_state_e;

  // Byte count of an access; "no write" is treated as a full word.
  function automatic logic [2:0] memw_nbytes(memw_e t);
    logic [2:0] n;
    unique case (t)
      MemwSb:  n = 3'd1;
      MemwSh:  n = 3'd2;
      MemwSw:  n = 3'd4;
      MemwNo:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises 1/2/4-byte MEM-stage loads/stores onto a byte-wide synchronous RAM,
// little-endian, stalling the pipeline until a one-cycle response pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  memw_e                 i_mem_type,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [31:0]           i_mem_wdata,
  output logic                  o_mem_stall,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_wr,
  output logic [7:0]            o_ram_dout,
  input  logic [7:0]            i_ram_din
);

  mc_state_e             r_state, w_state_d;
  logic [2:0]            r_cnt, w_cnt_d;
  logic [2:0]            r_n, w_n_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [31:0]           r_wdata, w_wdata_d;
  logic [31:0]           r_rdata, w_rdata_d;
  // Last values driven to the RAM port, held while no new byte is being presented.
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [7:0]            r_last_dout;

  logic [ADDR_WIDTH-1:0] w_byte_addr;
  logic [1:0]            w_rd_lane;

  assign w_byte_addr = r_addr + ADDR_WIDTH'(r_cnt);
  assign w_rd_lane   = r_cnt[1:0] - 2'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= McIdle;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_last_addr <= '0;
      r_last_dout <= 8'd0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_n         <= w_n_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_rdata     <= w_rdata_d;
      r_last_addr <= o_ram_addr;
      r_last_dout <= o_ram_dout;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_n_d     = r_n;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rdata_d = r_rdata;
    unique case (r_state)
      McIdle: begin
        w_cnt_d = 3'd0;
        if (i_mem_write) begin
          w_state_d = McWrite;
          w_addr_d  = i_mem_addr;
          w_wdata_d = i_mem_wdata;
          w_n_d     = memw_nbytes(i_mem_type);
        end else if (i_mem_read) begin
          w_state_d = McRead;
          w_addr_d  = i_mem_addr;
          w_n_d     = memw_nbytes(i_mem_type);
          w_rdata_d = 32'd0;
        end
      end
      McWrite: begin
        if (r_cnt == r_n - 3'd1) begin
          w_state_d = McDone;
          w_cnt_d   = 3'd0;
        end else begin
          w_cnt_d = r_cnt + 3'd1;
        end
      end
      McRead: begin
        // RAM data lags the address by one cycle, so cycle k returns byte k-1.
        if (r_cnt != 3'd0) begin
          w_rdata_d[{w_rd_lane, 3'b000} +: 8] = i_ram_din;
        end
        if (r_cnt == r_n) begin
          w_state_d = McDone;
          w_cnt_d   = 3'd0;
        end else begin
          w_cnt_d = r_cnt + 3'd1;
        end
      end
      McDone: begin
        w_state_d = McIdle;
        w_cnt_d   = 3'd0;
      end
      default: begin
        w_state_d = McIdle;
        w_cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    o_ram_wr   = 1'b0;
    o_ram_addr = r_last_addr;
    o_ram_dout = r_last_dout;
    unique case (r_state)
      McWrite: begin
        o_ram_wr   = 1'b1;
        o_ram_addr = w_byte_addr;
        o_ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
      end
      McRead: begin
        if (r_cnt < r_n) o_ram_addr = w_byte_addr;
      end
      default: begin
        o_ram_wr = 1'b0;
      end
    endcase
  end

  assign o_resp_valid = (r_state == McDone);
  assign o_resp_rdata = r_rdata;
  assign o_mem_stall  = (i_mem_read | i_mem_write) && (r_state != McDone);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single accesses plus reset-abort
// and back-to-back sequences, against a byte-wide synchronous RAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  memw_e       typ = MemwNo;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mem_read  (rd),
    .i_mem_write (wr),
    .i_mem_type  (typ),
    .i_mem_addr  (addr),
    .i_mem_wdata (wdata),
    .o_mem_stall (stall),
    .o_resp_valid(resp_valid),
    .o_resp_rdata(resp_rdata),
    .o_ram_addr  (ram_addr),
    .o_ram_wr    (ram_wr),
    .o_ram_dout  (ram_dout),
    .i_ram_din   (ram_din)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [logic [31:0]];
  logic [39:0] wlog [$];

  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr] = ram_dout;
      wlog.push_back({ram_addr, ram_dout});
    end
    ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // b2b: inputs are changed during the previous DONE cycle, accept happens next cycle.
  task automatic access(input logic w, input logic r, input memw_e t, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat,
                        input bit b2b, input bit drop, input string nm);
    int lat;
    int n;
    wlog.delete();
    wr = w; rd = r; typ = t; addr = a; wdata = d;
    if (b2b) @(negedge clk);
    else #1;
    chk({nm, " stall_accept"}, 40'(stall), 40'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i;
      if (resp_valid) break;
    end
    if (!resp_valid) lat = 99;
    chk({nm, " latency"}, 40'(lat), 40'(exp_lat));
    chk({nm, " stall_resp"}, 40'(stall), 40'd0);
    chk({nm, " rdata"}, 40'(resp_rdata), 40'(exp_rd));
    n = (t == MemwSb) ? 1 : (t == MemwSh) ? 2 : 4;
    if (w) begin
      chk({nm, " nwrites"}, 40'(wlog.size()), 40'(n));
      for (int k = 0; k < n && k < wlog.size(); k++)
        chk({nm, " wbyte"}, wlog[k], {a + 32'(k), d[8*k +: 8]});
    end else begin
      chk({nm, " nwrites"}, 40'(wlog.size()), 40'd0);
    end
    if (drop) begin
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      chk({nm, " resp_pulse"}, 40'(resp_valid), 40'd0);
    end
  endtask

  typedef struct {
    logic        w;
    logic        r;
    memw_e       t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, MemwSw, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 5};
    vecs[1] = '{1'b0, 1'b1, MemwSh, 32'h0000_0202, 32'h0,         32'h0000_8433, 4};
    vecs[2] = '{1'b0, 1'b1, MemwSw, 32'h0000_0200, 32'h0,         32'h8433_2211, 6};
    vecs[3] = '{1'b1, 1'b0, MemwSh, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'h8433_2211, 3};
    vecs[4] = '{1'b1, 1'b1, MemwSb, 32'h0000_0010, 32'h0000_005A, 32'h8433_2211, 2};
    vecs[5] = '{1'b0, 1'b1, MemwSb, 32'h0000_0101, 32'h0,         32'h0000_00BE, 3};
    vecs[6] = '{1'b0, 1'b1, MemwSw, 32'hFFFF_FFFF, 32'h0,         32'h0000_ABCD, 6};
    vecs[7] = '{1'b0, 1'b1, MemwNo, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 6};

    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h84;

    repeat (2) @(negedge clk);
    chk("rst ram_wr", 40'(ram_wr), 40'd0);
    chk("rst ram_addr", 40'(ram_addr), 40'd0);
    chk("rst ram_dout", 40'(ram_dout), 40'd0);
    chk("rst resp_valid", 40'(resp_valid), 40'd0);
    chk("rst resp_rdata", 40'(resp_rdata), 40'd0);
    chk("rst stall", 40'(stall), 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      access(vecs[v].w, vecs[v].r, vecs[v].t, vecs[v].a, vecs[v].d, vecs[v].exp_rd,
             vecs[v].exp_lat, 1'b0, 1'b1, $sformatf("vec%0d", v));

    // Reset asserted while byte 2 of a word store is on the RAM port.
    wlog.delete();
    wr = 1'b1; typ = MemwSw; addr = 32'h400; wdata = 32'h1122_3344;
    repeat (3) @(negedge clk);
    chk("abort pre ram_wr", 40'(ram_wr), 40'd1);
    chk("abort pre ram_addr", 40'(ram_addr), 40'h402);
    rst_n = 1'b0;
    #1;
    chk("abort ram_wr", 40'(ram_wr), 40'd0);
    chk("abort ram_addr", 40'(ram_addr), 40'd0);
    chk("abort rdata", 40'(resp_rdata), 40'd0);
    wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort resp_valid", 40'(resp_valid), 40'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort nwrites", 40'(wlog.size()), 40'd2);
    if (wlog.size() >= 2) begin
      chk("abort byte0", wlog[0], {32'h400, 8'h44});
      chk("abort byte1", wlog[1], {32'h401, 8'h33});
    end
    access(1'b0, 1'b1, MemwSb, 32'h401, 32'h0, 32'h0000_0033, 3, 1'b0, 1'b1, "post_rst lb");

    // Back-to-back with the request held continuously across the handshake.
    access(1'b1, 1'b0, MemwSb, 32'h300, 32'h0000_0077, 32'h0000_0033, 2, 1'b0, 1'b0, "b2b sb");
    access(1'b0, 1'b1, MemwSb, 32'h300, 32'h0, 32'h0000_0077, 3, 1'b1, 1'b0, "b2b lb");
    access(1'b1, 1'b0, MemwSw, 32'h304, 32'h0102_0304, 32'h0000_0077, 5, 1'b1, 1'b1, "b2b sw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
